// File: rtl/q2_serializer.sv
// rtl/q2_serializer.sv - parallel-in serial-out link transmitter with one-word holding buffer
// Words are shifted MSB first; frameSync marks the first bit and done the last bit of each word.
module q2_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] parIn,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             serialOut,
  output logic             frameSync,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    bitCnt, bitCntNext;
  logic [WIDTH-1:0] shifter, shifterNext;
  logic [WIDTH-1:0] buffer, bufferNext;
  logic             bufFull, bufFullNext;
  logic             accept;
  logic             lastBit;

  assign loadReady = !bufFull;
  assign accept    = loadValid && loadReady;
  assign lastBit   = (state == SHIFT) && (bitCnt == LAST_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shifter   <= '0;
      buffer    <= '0;
      bufFull   <= 1'b0;
      serialOut <= 1'b0;
      frameSync <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      shifter   <= shifterNext;
      buffer    <= bufferNext;
      bufFull   <= bufFullNext;
      // Flags are registered from next-state so they line up with the bit they describe.
      serialOut <= (stateNext == SHIFT) ? shifterNext[WIDTH-1] : 1'b0;
      frameSync <= (stateNext == SHIFT) && (bitCntNext == '0);
      done      <= (stateNext == SHIFT) && (bitCntNext == LAST_CNT);
      busy      <= (stateNext == SHIFT);
    end
  end

  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    shifterNext = shifter;
    bufferNext  = buffer;
    bufFullNext = bufFull;
    case (state)
      IDLE: begin
        if (accept) begin
          shifterNext = parIn;
          bitCntNext  = '0;
          stateNext   = SHIFT;
        end
      end
      SHIFT: begin
        if (lastBit) begin
          if (bufFull) begin
            shifterNext = buffer;
            bitCntNext  = '0;
            bufFullNext = 1'b0;
          end else if (accept) begin
            shifterNext = parIn;
            bitCntNext  = '0;
          end else begin
            bitCntNext = '0;
            stateNext  = IDLE;
          end
        end else begin
          if (accept) begin
            bufferNext  = parIn;
            bufFullNext = 1'b1;
          end
          shifterNext = {shifter[WIDTH-2:0], 1'b0};
          bitCntNext  = bitCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_q2_serializer.sv
// tb/tb_q2_serializer.sv - scoreboard bench for q2_serializer with a loopback receiver shift register
module tb_q2_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] parIn = '0;
  logic         loadValid = 1'b0;
  logic         loadReady;
  logic         serialOut;
  logic         frameSync;
  logic         busy;
  logic         done;

  q2_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .parIn     (parIn),
    .loadValid (loadValid),
    .loadReady (loadReady),
    .serialOut (serialOut),
    .frameSync (frameSync),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         b;
    logic         fs;
    logic         dn;
    logic [W-1:0] word;
  } exp_t;

  exp_t         sbQ[$];
  int           nChk = 0;
  int           nBad = 0;
  logic [W-1:0] rxReg;
  logic         rxPend = 1'b0;
  logic [W-1:0] rxWord = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic pushWord(input logic [W-1:0] w);
    exp_t e;
    for (int j = 0; j < W; j++) begin
      e.b    = w[W-1-j];
      e.fs   = (j == 0);
      e.dn   = (j == W - 1);
      e.word = w;
      sbQ.push_back(e);
    end
  endtask

  // Call at a negedge; returns at the negedge following the accepting edge.
  task automatic sendWord(input logic [W-1:0] w);
    logic rdy;
    parIn     = w;
    loadValid = 1'b1;
    rdy       = loadReady;
    chk("send_ready", rdy, 1);
    @(posedge clk);
    if (rdy) pushWord(w);
    @(negedge clk);
    loadValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sbQ.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 200, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Receiver end of the link: shifts in serialOut on the same clock.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) rxReg <= '0;
    else       rxReg <= {rxReg[W-2:0], serialOut};
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      chk("rst_serialOut", serialOut, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frameSync", frameSync, 0);
      chk("rst_done", done, 0);
      chk("rst_loadReady", loadReady, 1);
      rxPend = 1'b0;
    end else begin
      if (rxPend) begin
        chk("rx_word", rxReg, rxWord);
        rxPend = 1'b0;
      end
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        chk("serialOut", serialOut, e.b);
        chk("frameSync", frameSync, e.fs);
        chk("done", done, e.dn);
        chk("busy", busy, 1);
        if (e.dn) begin
          rxPend = 1'b1;
          rxWord = e.word;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_serialOut", serialOut, 0);
        chk("idle_frameSync", frameSync, 0);
        chk("idle_done", done, 0);
      end
    end
  end

  logic [W-1:0] contWords[3];

  initial begin
    int idx;
    int guard;
    logic rdy;
    contWords[0] = 8'h01;
    contWords[1] = 8'h02;
    contWords[2] = 8'h03;

    repeat (3) @(negedge clk);
    chk("reset_loadReady", loadReady, 1);
    rstn = 1'b1;
    @(negedge clk);

    sendWord(8'hA5);
    waitIdle();

    sendWord(8'h3C);
    waitIdle();

    // FF then 00, second word buffered during bit 2 of the first.
    sendWord(8'hFF);
    repeat (2) @(negedge clk);
    sendWord(8'h00);
    for (int c = 0; c < 5; c++) begin
      chk("bp_loadReady_low", loadReady, 0);
      @(negedge clk);
    end
    chk("bp_loadReady_back", loadReady, 1);
    waitIdle();

    // Pass-through: second word offered only on the lastBit cycle.
    sendWord(8'h5A);
    repeat (W - 1) @(negedge clk);
    sendWord(8'hC3);
    chk("pt_bufEmpty", loadReady, 1);
    waitIdle();

    // loadValid held high with an incrementing word.
    idx = 0;
    guard = 0;
    loadValid = 1'b1;
    while (idx < 3 && guard < 100) begin
      parIn = contWords[idx];
      rdy   = loadReady;
      @(posedge clk);
      if (rdy) begin
        pushWord(contWords[idx]);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    loadValid = 1'b0;
    chk("cont_count", idx, 3);
    waitIdle();

    // Reset in the middle of a word, then a clean restart.
    sendWord(8'hE7);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_serialOut", serialOut, 0);
    chk("async_busy", busy, 0);
    chk("async_frameSync", frameSync, 0);
    chk("async_done", done, 0);
    chk("async_loadReady", loadReady, 1);
    sbQ.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    sendWord(8'h96);
    waitIdle();

    chk("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule

// File: doc/q2_serializer.md
# q2_serializer

Parallel-in, serial-out transmitter for the 8-bit serial link. It is the transmit end paired with the serial-in/parallel-out shift-register receiver. It accepts words through a valid/ready load port and shifts them out one bit per clock, MSB first, with a frame-sync strobe on each word's first bit. A one-word holding buffer allows back-to-back words with no idle gap.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock, shared with the receiver's shift clock.
- rstn  input  1  asynchronous, active-low reset.
- parIn  input  WIDTH  word to transmit; sampled only on an accepted load.
- loadValid  input  1  producer has a word on parIn.
- loadReady  output  1  block can accept a word this cycle.
- serialOut  output  1  registered serial data, MSB of each word first.
- frameSync  output  1  registered; high exactly during the first bit of each word.
- busy  output  1  registered; high while a word is being shifted.
- done  output  1  registered; high exactly during the last bit of each word.

## Operation
- State: IDLE or SHIFT.
- Storage: a shift register of WIDTH bits, a bit counter of ceil(log2 WIDTH) bits, a holding buffer of WIDTH bits, and a bufFull flag.
- Accept: a load is accepted at a rising edge when loadValid=1 and loadReady=1.
- loadReady = !bufFull. It is combinational and does not depend on loadValid.
- lastBit = (state==SHIFT && bitCnt==WIDTH-1).
- At each edge, in priority order:
  - IDLE with accept: load parIn into the shifter, set bitCnt=0, go to SHIFT. The buffer stays empty.
  - lastBit with bufFull=1: move the buffer into the shifter, set bitCnt=0, clear bufFull, stay in SHIFT.
  - lastBit with bufFull=0 and accept: load parIn directly into the shifter (pass-through), set bitCnt=0, stay in SHIFT.
  - lastBit with no word available: go to IDLE.
  - SHIFT, not lastBit, with accept: write parIn into the buffer and set bufFull=1.
  - SHIFT, not lastBit: shift left by one and increment bitCnt.
- A simultaneous buffer drain and new accept cannot occur, because loadReady=0 whenever bufFull=1.
- Output registers are updated from the next-state values:
  - serialOut = shifter MSB while in SHIFT; 0 in IDLE.
  - frameSync = 1 when the next bitCnt is 0 and the next state is SHIFT.
  - done = 1 when the next bitCnt is WIDTH-1 and the next state is SHIFT.
  - busy = 1 when the next state is SHIFT.
- Bit order: MSB first. After WIDTH receiver clocks, bit[WIDTH-1] of the word lands at the receiver's parallel output MSB.

## Timing
- Reset (rstn=0, asynchronous): state=IDLE, bitCnt=0, bufFull=0, shifter=0, buffer=0. serialOut, frameSync, busy and done are all 0. loadReady=1.
- Reset mid-word aborts the word, discards the buffer, and forces serialOut=0 immediately, without waiting for a clock.
- Latency: a word accepted at edge k in IDLE drives bit WIDTH-1 on serialOut during cycle k+1 (after edge k), with frameSync=1 and busy=1.
  - Bit j (counting from MSB, j=0..WIDTH-1) appears in cycle k+1+j.
  - done=1 in cycle k+WIDTH.
  - busy falls after edge k+WIDTH if no word is pending.
- Streaming: with a word buffered or presented on the lastBit cycle, the first bit of the next word follows the last bit of the current one on the very next cycle.
  - Sustained throughput is one word per WIDTH cycles with no gap.
  - frameSync and done of adjacent words fall on consecutive cycles.
- Back-pressure: loadReady drops the cycle after the buffer fills. It rises again the cycle after the lastBit edge that drains the buffer.
- parIn is don't-care except at an accepting edge. loadValid may be held high continuously.

## Test plan
- Reset: rstn=0 mid-word. Required: serialOut, busy, frameSync and done go to 0 asynchronously; loadReady=1; the next load restarts cleanly from bit 7.
- Single word 8'hA5 accepted from IDLE at edge k. Required: serialOut sequence 1,0,1,0,0,1,0,1 in cycles k+1..k+8; frameSync only in k+1; done only in k+8; busy 0 from k+9.
- Loopback into the receiver shift register on the same clk, driving 8'h3C. Required: after 8 clocks the receiver's parallel output equals 8'h3C.
- Back-to-back words 8'hFF then 8'h00, with the second word loaded into the buffer during bit 2. Required: 16 contiguous bits, 8 ones then 8 zeros; busy never drops; loadReady low from buffer fill until the lastBit edge.
- Pass-through load: a word presented only during the lastBit cycle with the buffer empty. Required: no gap, frameSync in the following cycle, bufFull stays 0.
- Continuous loadValid=1 with an incrementing word 8'h01, 8'h02, 8'h03. Required: each word is accepted exactly once, with no duplicates or drops, and the serial stream reconstructs 01,02,03.
